// File: rtl/seq_num_alloc_pkg.sv
// Shared sequence-number helpers used by the allocator and its neighbours.
// Distances are computed at a fixed maximum width and masked down to n bits.
package seq_num_alloc_pkg;

  localparam int unsigned SEQ_MAX_W = 16;

  // (a - b) mod 2^n, for any n up to SEQ_MAX_W
  function automatic logic [SEQ_MAX_W-1:0] seq_dist(
    input logic [SEQ_MAX_W-1:0] a,
    input logic [SEQ_MAX_W-1:0] b,
    input int unsigned          n
  );
    logic [SEQ_MAX_W-1:0] mask;
    mask = '1;
    mask = mask >> (SEQ_MAX_W - n);
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/seq_num_alloc_if.sv
// Commit and squash broadcast notifications; the pipeline back end publishes,
// sequence-number consumers subscribe.
interface commit_notif_if #(
  parameter int unsigned p_seq_num_bits = 5
);
  logic                      val;
  logic [p_seq_num_bits-1:0] seq_num;

  modport master (output val, output seq_num);
  modport slave  (input  val, input  seq_num);
endinterface

interface squash_notif_if #(
  parameter int unsigned p_seq_num_bits = 5
);
  logic                      val;
  logic [p_seq_num_bits-1:0] seq_num;

  modport master (output val, output seq_num);
  modport slave  (input  val, input  seq_num);
endinterface

// File: rtl/seq_num_alloc.sv
// Circular sequence-number allocator: grants numbers at the tail, retires them
// in order at the head on commit, and rolls the tail back on squash.
module seq_num_alloc
  import seq_num_alloc_pkg::*;
#(
  parameter int unsigned p_seq_num_bits = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_val,
  output logic                      alloc_rdy,
  output logic [p_seq_num_bits-1:0] alloc_seq_num,
  commit_notif_if.slave             commit,
  squash_notif_if.slave             squash,
  output logic [p_seq_num_bits-1:0] oldest_seq_num,
  output logic [p_seq_num_bits:0]   num_inflight,
  output logic                      empty,
  output logic                      full,
  output logic                      protocol_err
);

  localparam int unsigned W  = p_seq_num_bits;
  localparam int unsigned CW = p_seq_num_bits + 1;
  localparam logic [CW-1:0] CAP = {1'b1, {W{1'b0}}};

  logic [W-1:0]         head, tail;
  logic [CW-1:0]        count;
  logic [W-1:0]         head_nxt, tail_nxt;
  logic [CW-1:0]        count_base, count_nxt;
  logic [SEQ_MAX_W-1:0] sq_dist;
  logic                 commit_ok, squash_ok, fire, err_nxt;

  assign empty          = (count == '0);
  assign full           = (count == CAP);
  assign alloc_rdy      = !full && !squash.val;
  assign alloc_seq_num  = tail;
  assign oldest_seq_num = head;
  assign num_inflight   = count;

  always_comb begin
    commit_ok  = commit.val && !empty && (commit.seq_num == head);
    sq_dist    = seq_dist(SEQ_MAX_W'(squash.seq_num), SEQ_MAX_W'(head), W);
    squash_ok  = squash.val && (sq_dist < SEQ_MAX_W'(count));
    fire       = alloc_val && alloc_rdy;
    head_nxt   = head;
    tail_nxt   = tail;
    count_base = count;
    if (commit_ok)
      head_nxt = head + W'(1);
    // squash and alloc are mutually exclusive because alloc_rdy drops on squash.val
    if (squash_ok) begin
      tail_nxt   = squash.seq_num + W'(1);
      count_base = CW'(sq_dist) + CW'(1);
    end else if (fire) begin
      tail_nxt   = tail + W'(1);
      count_base = count + CW'(1);
    end
    count_nxt = commit_ok ? (count_base - CW'(1)) : count_base;
    err_nxt   = protocol_err | (commit.val & ~commit_ok) | (squash.val & ~squash_ok);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      protocol_err <= 1'b0;
    end else begin
      head         <= head_nxt;
      tail         <= tail_nxt;
      count        <= count_nxt;
      protocol_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_seq_num_alloc.sv
// Randomized and directed check of seq_num_alloc (3-bit numbers, capacity 8)
// against a queue-of-in-flight-numbers model.
module tb_seq_num_alloc;

  localparam int unsigned NB  = 3;
  localparam int          CAP = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          alloc_val = 1'b0;
  logic          alloc_rdy;
  logic [NB-1:0] alloc_seq_num;
  logic [NB-1:0] oldest_seq_num;
  logic [NB:0]   num_inflight;
  logic          empty, full, protocol_err;

  commit_notif_if #(.p_seq_num_bits(NB)) cm ();
  squash_notif_if #(.p_seq_num_bits(NB)) sq ();

  seq_num_alloc #(.p_seq_num_bits(NB)) dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_val      (alloc_val),
    .alloc_rdy      (alloc_rdy),
    .alloc_seq_num  (alloc_seq_num),
    .commit         (cm),
    .squash         (sq),
    .oldest_seq_num (oldest_seq_num),
    .num_inflight   (num_inflight),
    .empty          (empty),
    .full           (full),
    .protocol_err   (protocol_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: in-flight numbers oldest-first, plus the next number to grant
  int q[$];
  int tail_m = 0;
  bit perr_m = 0;
  bit m_fire, m_cok, m_sok;
  int m_idx;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      tail_m = 0;
      perr_m = 0;
    end else begin
      m_fire = alloc_val && (q.size() < CAP) && !sq.val;
      m_cok  = cm.val && (q.size() > 0) && (q[0] == int'(cm.seq_num));
      m_idx  = -1;
      foreach (q[i]) if (q[i] == int'(sq.seq_num)) m_idx = i;
      m_sok  = sq.val && (m_idx >= 0);
      if (cm.val && !m_cok) perr_m = 1;
      if (sq.val && !m_sok) perr_m = 1;
      if (m_sok) begin
        while (q.size() > m_idx + 1) void'(q.pop_back());
        tail_m = (int'(sq.seq_num) + 1) % CAP;
      end
      if (m_cok) void'(q.pop_front());
      if (m_fire) begin
        q.push_back(tail_m);
        tail_m = (tail_m + 1) % CAP;
      end
    end
  end

  int e_cnt, e_head;
  always @(negedge clk) begin
    if (chk_on) begin
      e_cnt  = q.size();
      e_head = (e_cnt > 0) ? q[0] : tail_m;
      chk("alloc_rdy",      32'(alloc_rdy),      32'((e_cnt < CAP) && !sq.val));
      chk("alloc_seq_num",  32'(alloc_seq_num),  32'(tail_m));
      chk("oldest_seq_num", 32'(oldest_seq_num), 32'(e_head));
      chk("num_inflight",   32'(num_inflight),   32'(e_cnt));
      chk("empty",          32'(empty),          32'(e_cnt == 0));
      chk("full",           32'(full),           32'(e_cnt == CAP));
      chk("protocol_err",   32'(protocol_err),   32'(perr_m));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit a, input bit cv, input int cs, input bit sv, input int ss);
    alloc_val  = a;
    cm.val     = cv;
    cm.seq_num = NB'(cs);
    sq.val     = sv;
    sq.seq_num = NB'(ss);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1, 0, 0, 0, 0);
      tick();
    end
    idle();
  endtask

  int cs, ss;

  initial begin
    idle();
    tick();
    chk_on = 1;
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(num_inflight), 32'd0);
    chk("rst_rdy",   32'(alloc_rdy), 32'd1);
    tick();
    rst = 1'b1;

    // Eight back-to-back grants fill the window
    for (int i = 0; i < CAP; i++) begin
      drive(1, 0, 0, 0, 0);
      #1;
      chk("fill_grant", 32'(alloc_seq_num), 32'(i));
      tick();
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_rdy",  32'(alloc_rdy), 32'd0);

    // Commit while full: no grant this cycle, wrapped grant next cycle
    drive(1, 1, 0, 0, 0);
    #1;
    chk("full_commit_rdy", 32'(alloc_rdy), 32'd0);
    tick();
    drive(1, 0, 0, 0, 0);
    #1;
    chk("wrap_rdy",   32'(alloc_rdy), 32'd1);
    chk("wrap_grant", 32'(alloc_seq_num), 32'd0);
    tick();
    idle();
    chk("wrap_count", 32'(num_inflight), 32'd8);
    chk("wrap_head",  32'(oldest_seq_num), 32'd1);

    // Squash rolls the tail back to s+1
    do_reset();
    alloc_n(6);
    drive(1, 0, 0, 1, 2);
    #1;
    chk("sq_rdy_low", 32'(alloc_rdy), 32'd0);
    tick();
    idle();
    chk("sq_tail",  32'(alloc_seq_num), 32'd3);
    chk("sq_count", 32'(num_inflight), 32'd3);

    // Simultaneous commit of head and squash of a younger number
    do_reset();
    alloc_n(4);
    drive(0, 1, 0, 1, 1);
    tick();
    idle();
    chk("cs_head",  32'(oldest_seq_num), 32'd1);
    chk("cs_tail",  32'(alloc_seq_num), 32'd2);
    chk("cs_count", 32'(num_inflight), 32'd1);

    // Squash of head with commit of head empties the window
    do_reset();
    alloc_n(3);
    drive(0, 1, 0, 1, 0);
    tick();
    idle();
    chk("sqh_empty", 32'(empty), 32'd1);
    chk("sqh_head",  32'(oldest_seq_num), 32'd1);
    chk("sqh_tail",  32'(alloc_seq_num), 32'd1);

    // Illegal commit and illegal squash leave state alone and latch the error
    do_reset();
    alloc_n(2);
    drive(0, 1, 1, 0, 0);
    tick();
    idle();
    chk("badc_count", 32'(num_inflight), 32'd2);
    chk("badc_head",  32'(oldest_seq_num), 32'd0);
    chk("badc_err",   32'(protocol_err), 32'd1);
    drive(0, 0, 0, 1, 5);
    tick();
    idle();
    chk("bads_count", 32'(num_inflight), 32'd2);
    chk("bads_tail",  32'(alloc_seq_num), 32'd2);

    // Asynchronous reset mid-cycle discards everything
    alloc_n(3);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_count", 32'(num_inflight), 32'd0);
    chk("arst_tail",  32'(alloc_seq_num), 32'd0);
    chk("arst_err",   32'(protocol_err), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    tick();
    rst = 1'b1;
    drive(1, 0, 0, 0, 0);
    #1;
    chk("arst_first", 32'(alloc_seq_num), 32'd0);
    tick();
    idle();

    // Randomized traffic, mostly legal, with occasional illegal events and resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) cs = $urandom_range(0, CAP - 1);
      else cs = (q.size() > 0) ? q[0] : tail_m;
      if (q.size() > 0 && $urandom_range(0, 7) != 0) ss = q[$urandom_range(0, q.size() - 1)];
      else ss = $urandom_range(0, CAP - 1);
      drive($urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 4, cs,
            $urandom_range(0, 9) == 0, ss);
      tick();
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    idle();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_num_alloc.md
SEQ_NUM_ALLOC -- requirements
Module: seq_num_alloc

Interface
REQ-001 Parameter p_seq_num_bits, default 5; sequence-number width; capacity C = 2^p_seq_num_bits in-flight numbers.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 alloc_val  input  1  requester wants a sequence number this cycle.
REQ-005 alloc_rdy  output  1  allocator can grant this cycle; alloc fires when alloc_val && alloc_rdy.
REQ-006 alloc_seq_num  output  p_seq_num_bits  number granted on fire; equals tail pointer.
REQ-007 commit  CommitNotif subscriber port  -  uses val and seq_num only; other fields ignored.
REQ-008 squash  SquashNotif subscriber port  -  uses val and seq_num only; target ignored.
REQ-009 oldest_seq_num  output  p_seq_num_bits  head pointer (oldest in-flight number).
REQ-010 num_inflight  output  p_seq_num_bits+1  in-flight count, 0..C.
REQ-011 empty / full  output  1 each  count == 0 / count == C.
REQ-012 protocol_err  output  1  sticky flag, set on illegal commit or squash.

Function
REQ-013 State: head, tail (p_seq_num_bits, wrap mod C) and count (p_seq_num_bits+1), all registered.
REQ-014 alloc_rdy = !full && !squash.val; combinational; no same-cycle bypass of commit-freed slots.
REQ-015 On alloc fire: tail <- tail+1 mod C; count +1; latency 0 (number valid same cycle as rdy).
REQ-016 Commit legal iff commit.val && !empty && commit.seq_num == head.
REQ-017 Legal commit: head <- head+1 mod C; count -1.
REQ-018 In-flight test: d = (s - head) mod C; s in flight iff d < count.
REQ-019 Squash legal iff squash.val && s in flight (s = squash.seq_num).
REQ-020 Legal squash: s itself survives; all younger numbers freed; tail <- s+1 mod C; count <- d+1 (before commit adjustment).
REQ-021 Simultaneous legal squash and legal commit: apply both; count <- d+1-1 = d; head <- head+1; tail <- s+1.
REQ-022 Squash with s == head together with commit of head: result empty, head == tail == s+1.
REQ-023 Alloc cannot fire with squash (REQ-014); alloc with commit applies both, count unchanged.
REQ-024 Illegal commit or illegal squash: state unchanged for that event; protocol_err <- 1 next edge; legal concurrent events still apply.
REQ-025 Wrap-around: head/tail wrap mod C; full distinguished from empty by count only.
REQ-026 protocol_err cleared only by reset.

Reset
REQ-027 While rst low (async assert): head = 0, tail = 0, count = 0, protocol_err = 0; hence alloc_seq_num = 0, oldest_seq_num = 0, empty = 1, full = 0, alloc_rdy = !squash.val.
REQ-028 Reset mid-operation discards all in-flight numbers; first alloc after deassert returns 0.

Structure
REQ-029 Modular distance helper (seq_dist(a,b) = (a-b) mod 2^n) lives in the shared sequence-number package; no local typedefs.
REQ-030 Single module; no sub-module; CommitNotif/SquashNotif interfaces reused unchanged.

Verification (p_seq_num_bits = 3, C = 8)
REQ-031 Reset, 8 alloc fires back-to-back -> seq 0..7 granted, full = 1, alloc_rdy = 0 on 9th cycle.
REQ-032 Full, commit seq 0 with alloc_val high same cycle -> no grant that cycle; next cycle grant seq 0 (wrapped), count = 8.
REQ-033 Alloc 0..5, squash s = 2 -> tail = 3, count = 3, next grant = 3, alloc_rdy low during squash cycle.
REQ-034 Alloc 0..3, same cycle commit 0 and squash s = 1 -> head = 1, tail = 2, count = 1.
REQ-035 Alloc 0..1, commit seq 1 (not head) -> state unchanged, protocol_err = 1; squash s = 5 (not in flight) also ignored.
REQ-036 Alloc 0..4, assert rst mid-cycle -> outputs reset immediately; after deassert first grant = 0, protocol_err = 0.
